i2s_dac_tx: RTL and testbench

// Transmit end of the codec audio path. Accepts processed stereo samples (signed 32-bit L/R,
// e.g. from the echo stage) over a valid/ready handshake and serialises them onto the

---
 rtl/audio_pkg.sv | 11 +
 rtl/edge_sync.sv | 36 +++
 rtl/i2s_dac_tx.sv | 131 +++++++++++++
 tb/tb_i2s_dac_tx.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio-path types: sample width and the stereo pair payload.
package audio_pkg;

  localparam int unsigned AUDIO_W = 32;

  typedef struct packed {
    logic signed [AUDIO_W-1:0] l;
    logic signed [AUDIO_W-1:0] r;
  } stereo_sample_t;

endpackage

// File: rtl/edge_sync.sv
// Two-flop synchroniser for an asynchronous codec clock pin, with registered
// one-cycle rise/fall flags (asserted 3 clk cycles after the pin edge).
module edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_i,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;
  logic rise_q;
  logic fall_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
      rise_q <= sync_q & ~prev_q;
      fall_q <= ~sync_q & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S DAC transmitter: one-pair holding register feeding an MSB-first serialiser
// slaved to codec-driven BCLK/DACLRCK, with a 1-BCLK delay slot after each LRCK edge.
module i2s_dac_tx
  import audio_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = AUDIO_W,
  parameter int unsigned SAMPLE_BITS = 24
) (
  input  logic                         CLOCK_50,
  input  logic                         reset,
  input  logic signed [DATA_WIDTH-1:0] sample_L,
  input  logic signed [DATA_WIDTH-1:0] sample_R,
  input  logic                         sample_valid,
  output logic                         sample_ready,
  input  logic                         AUD_BCLK,
  input  logic                         AUD_DACLRCK,
  output logic                         AUD_DACDAT,
  output logic                         underrun
);

  localparam int unsigned SB    = SAMPLE_BITS;
  localparam int unsigned CNT_W = $clog2(SB + 1);

  logic bclk_rise_unused;
  logic bclk_fall;
  logic lrck_rise;
  logic lrck_fall;

  edge_sync u_bclk_sync (
    .clk     (CLOCK_50),
    .reset   (reset),
    .async_i (AUD_BCLK),
    .rise_o  (bclk_rise_unused),
    .fall_o  (bclk_fall)
  );

  edge_sync u_lrck_sync (
    .clk     (CLOCK_50),
    .reset   (reset),
    .async_i (AUD_DACLRCK),
    .rise_o  (lrck_rise),
    .fall_o  (lrck_fall)
  );

  stereo_sample_t           hold_q,     hold_d;
  logic                     ready_q,    ready_d;
  logic signed [AUDIO_W-1:0] active_r_q, active_r_d;
  logic [SB-1:0]            shift_q,    shift_d;
  logic [CNT_W-1:0]         bit_idx_q,  bit_idx_d;
  logic                     synced_q,   synced_d;
  logic                     dacdat_q,   dacdat_d;
  logic                     underrun_q, underrun_d;

  // Low-order bits are dropped by truncation to the codec word length.
  logic [2*(AUDIO_W-SB)-1:0] trunc_unused;
  assign trunc_unused = {hold_q.l[AUDIO_W-SB-1:0], active_r_q[AUDIO_W-SB-1:0]};

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hold_q     <= '0;
      ready_q    <= 1'b1;
      active_r_q <= '0;
      shift_q    <= '0;
      bit_idx_q  <= '0;
      synced_q   <= 1'b0;
      dacdat_q   <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      ready_q    <= ready_d;
      active_r_q <= active_r_d;
      shift_q    <= shift_d;
      bit_idx_q  <= bit_idx_d;
      synced_q   <= synced_d;
      dacdat_q   <= dacdat_d;
      underrun_q <= underrun_d;
    end
  end

  always_comb begin
    hold_d     = hold_q;
    ready_d    = ready_q;
    active_r_d = active_r_q;
    shift_d    = shift_q;
    bit_idx_d  = bit_idx_q;
    synced_d   = synced_q;
    dacdat_d   = dacdat_q;
    underrun_d = 1'b0;

    // Capture only into an empty holding register; a full one is drained at LRCK fall.
    if (sample_valid && ready_q) begin
      hold_d.l = AUDIO_W'(sample_L);
      hold_d.r = AUDIO_W'(sample_R);
      ready_d  = 1'b0;
    end

    if (lrck_fall) begin
      synced_d = 1'b1;
      if (!ready_q) begin
        active_r_d = hold_q.r;
        shift_d    = hold_q.l[AUDIO_W-1 -: SB];
        ready_d    = 1'b1;
      end else begin
        active_r_d = '0;
        shift_d    = '0;
        underrun_d = 1'b1;
      end
    end else if (lrck_rise) begin
      shift_d = synced_q ? active_r_q[AUDIO_W-1 -: SB] : '0;
    end

    // An LRCK edge claims any coincident BCLK fall as the I2S delay slot.
    if (lrck_fall || lrck_rise) begin
      bit_idx_d = '0;
      dacdat_d  = 1'b0;
    end else if (bclk_fall) begin
      if (bit_idx_q < CNT_W'(SB)) begin
        dacdat_d  = shift_q[SB-1];
        shift_d   = {shift_q[SB-2:0], 1'b0};
        bit_idx_d = bit_idx_q + CNT_W'(1);
      end else begin
        dacdat_d = 1'b0;
      end
    end
  end

  assign sample_ready = ready_q;
  assign AUD_DACDAT   = dacdat_q;
  assign underrun     = underrun_q;

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: BCLK = 16 clk, 32 BCLK per channel, 24-bit words.
module tb_i2s_dac_tx;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] sample_l = '0;
  logic [31:0] sample_r = '0;
  logic        valid = 1'b0;
  logic        ready;
  logic        bclk;
  logic        lrck;
  logic        dac;
  logic        ur;

  int t = 0;
  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;
  always @(posedge clk) t <= t + 1;

  // Codec master: LRCK toggles together with a BCLK falling edge every 512 clk.
  assign bclk = ((t % 16) >= 8);
  assign lrck = (((t / 512) % 2) == 1);

  i2s_dac_tx #(.DATA_WIDTH(32), .SAMPLE_BITS(24)) dut (
    .CLOCK_50     (clk),
    .reset        (reset),
    .sample_L     (sample_l),
    .sample_R     (sample_r),
    .sample_valid (valid),
    .sample_ready (ready),
    .AUD_BCLK     (bclk),
    .AUD_DACLRCK  (lrck),
    .AUD_DACDAT   (dac),
    .underrun     (ur)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    compared++;
    assert (obs === exp_v) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h (t=%0d)", tag, obs, exp_v, t);
    end
  endtask

  task automatic goto(input int tt);
    if (t > tt) begin
      compared++;
      mismatched++;
      $error("FAIL goto: t=%0d already past %0d", t, tt);
    end
    while (t < tt) @(negedge clk);
  endtask

  // Reference I2S slot: BCLK 0 is the delay slot, 1..24 carry MSB..LSB, rest zero.
  function automatic logic exp_bit(input logic [23:0] w, input int k);
    if (k >= 1 && k <= 24) return w[5'(24 - k)];
    return 1'b0;
  endfunction

  task automatic check_bits(input int c, input logic [23:0] w, input string tag,
                            input int k_lo, input int k_hi);
    for (int k = k_lo; k <= k_hi; k++) begin
      goto(c * 512 + 16 * k + 12);
      chk($sformatf("%s_b%0d", tag, k), 32'(dac), 32'(exp_bit(w, k)));
    end
  endtask

  task automatic check_left(input int c, input logic exp_ur, input string tag);
    goto(c * 512 + 3);
    chk({tag, "_ur_pre"}, 32'(ur), 32'd0);
    goto(c * 512 + 4);
    chk({tag, "_ur"}, 32'(ur), 32'(exp_ur));
    goto(c * 512 + 5);
    chk({tag, "_ur_post"}, 32'(ur), 32'd0);
  endtask

  task automatic push(input logic [31:0] l, input logic [31:0] r);
    int n;
    n = 0;
    sample_l = l;
    sample_r = r;
    valid    = 1'b1;
    while (!ready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("push_ready", 32'(ready), 32'd1);
    @(negedge clk);
    valid = 1'b0;
  endtask

  initial begin
    // Reset values
    goto(10);
    chk("rst_dac", 32'(dac), 32'd0);
    chk("rst_ur", 32'(ur), 32'd0);
    chk("rst_ready", 32'(ready), 32'd1);
    goto(20);
    reset = 1'b0;

    // Idle: unsynced right frame, then two underrunning left frames
    check_bits(1, 24'h0, "t1_c1", 0, 31);
    check_left(2, 1'b1, "t1_c2");
    chk("t1_ready", 32'(ready), 32'd1);
    check_bits(2, 24'h0, "t1_c2", 0, 31);
    check_bits(3, 24'h0, "t1_c3", 0, 31);
    check_left(4, 1'b1, "t1_c4");
    check_bits(4, 24'h0, "t1_c4", 0, 31);
    check_bits(5, 24'h0, "t1_c5", 0, 31);

    // Single pair, truncated to the top 24 bits
    push(32'h8000_0001, 32'h1234_5678);
    check_left(6, 1'b0, "t2_c6");
    check_bits(6, 24'h800000, "t2_l", 0, 31);
    check_bits(7, 24'h123456, "t2_r", 0, 31);

    // Back-to-back pairs: second stalls until the holding register drains
    push(32'h7FFF_FF80, 32'hA5A5_A5A5);
    sample_l = 32'hFFFF_FFFF;
    sample_r = 32'h0F0F_0F00;
    valid    = 1'b1;
    goto(8 * 512 + 3);
    chk("t3_stall", 32'(ready), 32'd0);
    chk("t3_ur_pre", 32'(ur), 32'd0);
    goto(8 * 512 + 4);
    chk("t3_ready_rise", 32'(ready), 32'd1);
    chk("t3_ur", 32'(ur), 32'd0);
    goto(8 * 512 + 5);
    valid = 1'b0;
    chk("t3_second_taken", 32'(ready), 32'd0);
    check_bits(8, 24'h7FFFFF, "t3_al", 0, 31);
    check_bits(9, 24'hA5A5A5, "t3_ar", 0, 31);
    check_left(10, 1'b0, "t3_c10");
    check_bits(10, 24'hFFFFFF, "t3_bl", 0, 31);
    check_bits(11, 24'h0F0F0F, "t3_br", 0, 31);

    // valid in the exact LRCK-fall flag cycle with an empty holding register
    goto(12 * 512 + 3);
    chk("t4_ur_pre", 32'(ur), 32'd0);
    sample_l = 32'h0000_0100;
    sample_r = 32'h8000_0000;
    valid    = 1'b1;
    goto(12 * 512 + 4);
    valid = 1'b0;
    chk("t4_ur", 32'(ur), 32'd1);
    chk("t4_held", 32'(ready), 32'd0);
    goto(12 * 512 + 5);
    chk("t4_ur_post", 32'(ur), 32'd0);
    check_bits(12, 24'h0, "t4_c12", 0, 31);
    check_bits(13, 24'h0, "t4_c13", 0, 31);
    check_left(14, 1'b0, "t4_c14");
    check_bits(14, 24'h000001, "t4_l", 0, 31);
    check_bits(15, 24'h800000, "t4_r", 0, 31);

    // Reset for 3 cycles mid right word, after bit 10 has been driven
    push(32'h1357_9BDF, 32'hFEDC_BA98);
    check_left(16, 1'b0, "t5_c16");
    push(32'h1111_1111, 32'h2222_2222);
    check_bits(16, 24'h13579B, "t5_l", 0, 31);
    check_bits(17, 24'hFEDCBA, "t5_r", 0, 10);
    goto(17 * 512 + 16 * 10 + 13);
    reset = 1'b1;
    goto(17 * 512 + 16 * 10 + 14);
    chk("t5_rst_dac", 32'(dac), 32'd0);
    chk("t5_rst_ready", 32'(ready), 32'd1);
    chk("t5_rst_ur", 32'(ur), 32'd0);
    goto(17 * 512 + 16 * 10 + 16);
    reset = 1'b0;
    push(32'h00FF_00FF, 32'hC000_0000);
    check_bits(17, 24'h0, "t5_after", 11, 31);
    check_left(18, 1'b0, "t5_c18");
    check_bits(18, 24'h00FF00, "t5_fl", 0, 31);
    check_bits(19, 24'hC00000, "t5_fr", 0, 31);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
